// File: rtl/rr_mux_pkg.sv
// +------------------------------------------------------------------+
// | rr_mux_pkg : shared defaults and index-width helper for rr_mux   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rr_mux_pkg;

  localparam int c_def_n_ch = 4;
  localparam int c_def_w    = 4;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant, masked/unmasked    |
// | double priority encoder.  Rev 1.0                                |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_CH = c_def_n_ch,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [N_CH-1:0] w_mask;
  logic [N_CH-1:0] w_masked_req;
  logic            w_found;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_mask[i] = (SEL_W'(i) >= ptr);
    end
  end

  assign w_masked_req = req & w_mask;

  // Requests at or above ptr win first; the unmasked pass covers the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && w_masked_req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        w_found   = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        w_found   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_reg.sv
// +------------------------------------------------------------------+
// | rr_mux_reg : round-robin N:1 mux into a one-entry output register|
// | Option: RR_MUX_PKT_LOCK_EN (packet lock on in_last).  Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int N_CH = c_def_n_ch,
  parameter int W    = c_def_w,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]   in_last,
  output logic              out_last,
`endif
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_load;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_grant;
  logic [SEL_W-1:0] w_idx;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_next;
  logic [W-1:0]     w_ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign w_ch_data[i] = in_data[i*W +: W];
  end

`ifdef RR_MUX_PKT_LOCK_EN
  logic             r_locked;
  logic [SEL_W-1:0] r_lock_idx;
  logic             r_out_last;

  // While a packet is open only its owner may be granted.
  always_comb begin
    w_req = in_valid;
    if (r_locked) begin
      w_req = in_valid & (N_CH'(1) << r_lock_idx);
    end
  end
`else
  assign w_req = in_valid;
`endif

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign w_load     = !r_out_valid || out_ready;
  assign in_ready   = (w_load && !rst) ? w_grant : '0;
  assign w_xfer     = |(in_valid & in_ready);
  assign w_ptr_next = (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_idx];
      r_out_sel   <= w_idx;
`ifdef RR_MUX_PKT_LOCK_EN
      if (in_last[w_idx]) begin
        r_ptr <= w_ptr_next;
      end
`else
      r_ptr <= w_ptr_next;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_locked   <= !in_last[w_idx];
      r_lock_idx <= w_idx;
      r_out_last <= in_last[w_idx];
    end
  end

  assign out_last = r_out_last;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
// +------------------------------------------------------------------+
// | tb_rr_mux_reg : vector table, directed corners, random vs model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic        in_valid1;
  logic [7:0]  in_data1;
  logic        in_ready1;
  logic        out_valid1;
  logic [7:0]  out_data1;
  logic        out_sel1;
  logic        out_ready1;

`ifdef RR_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic        in_last1;
  logic        out_last1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_reg #(.N_CH(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_reg #(.N_CH(1), .W(8)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last1),
    .out_last  (out_last1),
`endif
    .in_ready  (in_ready1),
    .out_valid (out_valid1),
    .out_data  (out_data1),
    .out_sel   (out_sel1),
    .out_ready (out_ready1)
  );

  typedef struct packed {
    logic [3:0]  iv;
    logic [15:0] d;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t tbl [16];

  // reference model state
  bit      m_ov;
  int      m_od;
  int      m_os;
  int      m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ov = 0; m_od = 0; m_os = 0; m_ptr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    in_last = 4'hF; in_last1 = 1'b1;
`endif

    //           iv     data      ordy  rdy   ov    od     os
    tbl[0]  = '{4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0};
    tbl[1]  = '{4'hF, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
    tbl[2]  = '{4'hF, 16'hDCBA, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2};
    tbl[3]  = '{4'hF, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
    tbl[4]  = '{4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0};
    tbl[5]  = '{4'h4, 16'h0500, 1'b1, 4'h4, 1'b1, 4'h5, 2'd2};
    tbl[6]  = '{4'h4, 16'h0500, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
    tbl[7]  = '{4'h4, 16'h0500, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
    tbl[8]  = '{4'h4, 16'h0500, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
    tbl[9]  = '{4'h0, 16'h0500, 1'b1, 4'h0, 1'b0, 4'h5, 2'd2};
    tbl[10] = '{4'h2, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
    tbl[11] = '{4'hA, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
    tbl[12] = '{4'hA, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
    tbl[13] = '{4'h0, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'hB, 2'd1};
    tbl[14] = '{4'hF, 16'hDCBA, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2};
    tbl[15] = '{4'h0, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'hC, 2'd2};

    tick();
    tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_os", out_sel, 0);
    chk("rst_rdy", in_ready, 0);
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      in_valid  = tbl[r].iv;
      in_data   = tbl[r].d;
      out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", r), in_ready, tbl[r].exp_rdy);
      tick();
      chk($sformatf("tbl%0d_ov", r), out_valid, tbl[r].exp_ov);
      chk($sformatf("tbl%0d_od", r), out_data, tbl[r].exp_od);
      chk($sformatf("tbl%0d_os", r), out_sel, tbl[r].exp_os);
    end

    // async reset while holding a beat (ptr=3 here, so ch3/D is loaded)
    in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b0;
    tick();
    chk("pre_rst_ov", out_valid, 1);
    chk("pre_rst_od", out_data, 4'hD);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ov", out_valid, 0);
    chk("async_od", out_data, 0);
    chk("async_os", out_sel, 0);
    chk("async_rdy", in_ready, 0);
    tick();
    in_valid = 4'hA; out_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", in_ready, 4'h2);
    tick();
    chk("post_rst_od", out_data, 4'hB);
    chk("post_rst_os", out_sel, 1);

    // single-channel instance: plain pipeline register
    in_valid1 = 1'b1; in_data1 = 8'h11; out_ready1 = 1'b1;
    #1;
    chk("n1_rdy0", in_ready1, 1);
    tick();
    chk("n1_od0", out_data1, 8'h11);
    chk("n1_os0", out_sel1, 0);
    in_data1 = 8'h22;
    tick();
    chk("n1_od1", out_data1, 8'h22);
    chk("n1_ov1", out_valid1, 1);
    in_valid1 = 1'b0;
    tick();
    chk("n1_drain", out_valid1, 0);

    // random traffic against the scan-order model
    in_valid = '0; out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  iv;
      logic [15:0] d;
      logic        ordy;
      logic [3:0]  exp_rdy;
      bit          load;
      int          g;
      chk("rnd_ov", out_valid, m_ov);
      if (m_ov) begin
        chk("rnd_od", out_data, m_od);
        chk("rnd_os", out_sel, m_os);
      end
      iv   = 4'($urandom);
      d    = 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      load = !m_ov || ordy;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'h0;
      chk("rnd_rdy", in_ready, exp_rdy);
      if (load && g >= 0) begin
        m_ov = 1; m_od = int'(d[g*4 +: 4]); m_os = g; m_ptr = (g + 1) % 4;
      end else if (ordy) begin
        m_ov = 0;
      end
      tick();
    end

`ifdef RR_MUX_PKT_LOCK_EN
    in_valid = '0; out_ready = 1'b0;
    do_reset();
    in_data = 16'hDCBA; out_ready = 1'b1;
    in_valid = 4'h3; in_last = 4'h0;
    #1; chk("lk1_rdy", in_ready, 4'h1);
    tick(); chk("lk1_ol", out_last, 0); chk("lk1_os", out_sel, 0);
    #1; chk("lk2_rdy", in_ready, 4'h1);
    tick(); chk("lk2_ol", out_last, 0);
    in_valid = 4'h2;
    #1; chk("lk_hold_rdy", in_ready, 4'h0);
    tick(); chk("lk_hold_ov", out_valid, 0);
    in_valid = 4'h3; in_last = 4'h1;
    #1; chk("lk3_rdy", in_ready, 4'h1);
    tick(); chk("lk3_ol", out_last, 1); chk("lk3_os", out_sel, 0);
    in_last = 4'h0;
    #1; chk("lk4_rdy", in_ready, 4'h2);
    tick(); chk("lk4_os", out_sel, 1); chk("lk4_od", out_data, 4'hB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
